uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO and a valid/ready byte interface. It replaces fixed-message debug transmitters: any producer (debug formatter, CPU bus bridge) pushes words, and the block serialises them back-to-back with configurable baud, data width, parity and stop bits. It sits between on-chip debug/CPU logic and the board's TX pin (27 MHz Tang Nano clock by default).

Parameters:
- CLK_FREQ, 27000000, system clock in Hz.
- BAUD, 115200, line rate in bit/s.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_BITS  word to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a word. A transfer occurs on a rising edge where in_valid && in_ready.
- uart_tx  out  1  serial line; idle high.
- busy  out  1  a frame is in progress or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Divisor: DIV = (CLK_FREQ + BAUD/2) / BAUD, i.e. rounded; 234 at the defaults. Every bit, including start, data, parity and stop, lasts exactly DIV clk cycles.
- Elaboration error if DIV < 2, FIFO_DEPTH is not a power of two, PARITY > 2, STOP_BITS is not 1 or 2, or DATA_BITS is outside 5..9.
- Reset values: uart_tx = 1, busy = 0, fifo_count = 0, FSM in IDLE, FIFO pointers 0. in_ready = 0 while reset is high; writes presented during reset are dropped.
- in_ready = !reset && (fifo_count < FIFO_DEPTH). It is registered-state based and does not depend combinationally on a pop in the same cycle. A slot freed by a pop is visible as in_ready = 1 the following cycle.
- FIFO: first in, first out; pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle leave fifo_count unchanged. A push while full cannot occur. A pop only occurs when the FIFO is non-empty.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: uart_tx = 1. If the FIFO is non-empty, pop the head into the shift register and enter START; uart_tx = 0 from that edge.
  - Latency: a word accepted at edge k into an empty FIFO with the FSM in IDLE drives uart_tx low after edge k+1.
  - START: after DIV cycles, enter DATA and drive bit 0.
  - DATA: data is sent LSB first. Each bit is held DIV cycles. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
  - PARITY: odd mode sends ~^data; even mode sends ^data. The bit is held DIV cycles.
  - STOP: uart_tx = 1 for STOP_BITS*DIV cycles.
  - At the end of STOP: if the FIFO is non-empty, pop and start the next frame on the same edge, with no idle gap. Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV cycles. At the defaults (8N1) this is 2340 cycles.
- Baud and bit counters are sized from DIV and DATA_BITS; they never wrap inside a bit.
- busy = (state != IDLE) || (fifo_count != 0). It is high on the edge after the first accept and falls on the edge the last STOP ends with the FIFO empty.
- Reset mid-frame: on the reset edge, uart_tx returns high immediately, the FIFO is flushed and the FSM returns to IDLE. No partial frame resumes.
- Simultaneous events:
  - A push into an empty FIFO on the same edge the FSM checks emptiness is not seen until the next edge (+1 cycle).
  - A push while the FSM pops the last entry leaves fifo_count = 1.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PARITY_NONE/ODD/EVEN = 0/1/2;
  - FSM state encodings;
  - a constant function uart_div(clk_freq, baud) returning the rounded divisor.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): single clock, synchronous reset, with push/pop/full/empty/count outputs. It is reused later by the UART RX path.
- The FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan:
1. Defaults: reset, then write 0x48. Required: uart_tx low one cycle after the accept edge, then bits 0,0,0,1,0,0,1,0, each 234 cycles, then stop high for 234 cycles. Total 2340 cycles; busy deasserts on the final edge.
2. Write "Hello\r\n" (7 bytes) on consecutive cycles. Required: in_ready stays 1 throughout; frames are contiguous with no idle cycles between stop and start; total 16380 cycles; decoded bytes 48 65 6C 6C 6F 0D 0A.
3. Hold in_valid for 20 incrementing bytes 0x00–0x13. Required: in_ready drops when fifo_count = 16 and re-asserts one cycle after each pop; all 20 bytes are received in order with no loss or duplication.
4. PARITY = 2: 0x55 gives parity bit 0 and 0x07 gives 1. PARITY = 1: 0x55 gives parity bit 1. Frame length is 2574 cycles.
5. STOP_BITS = 2, DATA_BITS = 7, two queued words. Required: stop high for 468 cycles, then the next start bit immediately; frame length 2340 cycles.
6. Queue 3 bytes and assert reset during data bit 3 of frame 2. Required: uart_tx = 1, fifo_count = 0, busy = 0 and in_ready = 0 during reset. After release, writing 0xA5 produces one clean frame of 2340 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (and the future RX path).
//   - parity mode encodings
//   - transmit FSM state encoding
//   - uart_div(): rounded clock-to-baud divisor, usable in constant expressions
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Rounded divisor; the sum is formed in 64 bits so fast clocks cannot overflow.
    function automatic int uart_div(input int clk_freq, input int baud);
        return int'((longint'(clk_freq) + longint'(baud / 2)) / longint'(baud));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
// Ports:
//   clk, reset          clock and synchronous reset (flushes pointers and count)
//   push, push_data     write request and data; ignored while full
//   pop, pop_data       read request; pop_data always shows the current head
//   full, empty         occupancy flags
//   count               current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO over a valid/ready word interface.
// Words are serialised LSB first, back-to-back while the FIFO holds data.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   in_data        word to transmit (DATA_BITS wide)
//   in_valid       in_data is valid; accepted on a rising edge with in_ready
//   in_ready       FIFO has room (low during reset)
//   uart_tx        serial line, idle high
//   busy           frame in progress or FIFO non-empty
//   fifo_count     current FIFO occupancy
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line high, waiting for the FIFO to become non-empty
// ST_START  | start bit (low) for DIV cycles
// ST_DATA   | data bits, LSB first, DIV cycles each
// ST_PARITY | parity bit for DIV cycles (only when PARITY != none)
// ST_STOP   | line high for STOP_BITS*DIV cycles, then next frame or idle
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV   = uart_div(CLK_FREQ, BAUD);
    localparam int CNT_W = $clog2(STOP_BITS * DIV);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: CLK_FREQ/BAUD gives a divisor below 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end

    tx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_head;
    logic                   start_frame;
    logic                   baud_tc;

    assign in_ready  = !reset && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign baud_tc = (baud_q == '0);
    assign uart_tx = tx_q;
    assign busy    = (state_q != ST_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) start_frame = 1'b1;
            end

            ST_START: begin
                if (baud_tc) begin
                    state_d = ST_DATA;
                    baud_d  = BIT_LOAD;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            ST_DATA: begin
                if (baud_tc) begin
                    if (bit_q == LAST_BIT) begin
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            baud_d  = BIT_LOAD;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            baud_d  = STOP_LOAD;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        baud_d  = BIT_LOAD;
                        shift_d = shift_q >> 1;
                        // Next bit is already sitting one place up in the register.
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            ST_PARITY: begin
                if (baud_tc) begin
                    state_d = ST_STOP;
                    baud_d  = STOP_LOAD;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            ST_STOP: begin
                if (baud_tc) begin
                    // Chain straight into the next frame so there is no idle gap.
                    if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (start_frame) begin
            fifo_pop = 1'b1;
            state_d  = ST_START;
            baud_d   = BIT_LOAD;
            bit_d    = '0;
            shift_d  = fifo_head;
            // Parity is fixed at load time since the shift register is consumed.
            par_d    = (PARITY == PARITY_ODD) ? ~^fifo_head : ^fifo_head;
            tx_d     = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. Five instances cover the parameter sets:
//   0: defaults 8N1 DIV=234        1: 8N1 DIV=16 (back-pressure)
//   2: 8E1 DIV=234                 3: 8O1 DIV=234
//   4: 7N2 DIV=234
module tb_uart_tx_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] in_data  [5];
    logic       in_valid [5];
    logic       in_ready [5];
    logic       tx_line  [5];
    logic       busy     [5];
    logic [4:0] fcount   [5];

    int   cyc;
    int   sel;
    logic mon_tx;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mon_tx = tx_line[sel];

    uart_tx_fifo u_def (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .uart_tx(tx_line[0]), .busy(busy[0]), .fifo_count(fcount[0]));

    uart_tx_fifo #(.BAUD(1687500)) u_fast (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .uart_tx(tx_line[1]), .busy(busy[1]), .fifo_count(fcount[1]));

    uart_tx_fifo #(.PARITY(2)) u_even (
        .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .uart_tx(tx_line[2]), .busy(busy[2]), .fifo_count(fcount[2]));

    uart_tx_fifo #(.PARITY(1)) u_odd (
        .clk(clk), .reset(reset), .in_data(in_data[3]), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .uart_tx(tx_line[3]), .busy(busy[3]), .fifo_count(fcount[3]));

    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u_s2d7 (
        .clk(clk), .reset(reset), .in_data(in_data[4][6:0]), .in_valid(in_valid[4]),
        .in_ready(in_ready[4]), .uart_tx(tx_line[4]), .busy(busy[4]), .fifo_count(fcount[4]));

    // Called at a negedge; returns at the negedge after the accepting edge, acc = that edge.
    task automatic push_word(input int idx, input logic [7:0] d, output int acc);
        int n;
        n = 0;
        in_data[idx]  = d;
        in_valid[idx] = 1'b1;
        while (in_ready[idx] !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        acc = cyc;
        in_valid[idx] = 1'b0;
    endtask

    // Waits for a start bit on the selected line and samples every cycle of
    // nbits bit periods. bits[i] is the i-th bit on the wire (bit 0 = start);
    // glitch flags any change inside a bit period. Returns on the last cycle.
    task automatic rx_frame(input int div, input int nbits, output logic [12:0] bits,
                            output int t_start, output bit glitch, output bit timeout);
        int n;
        bits = '0; glitch = 1'b0; timeout = 1'b0; t_start = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mon_tx !== 1'b0 && n < 5000);
        if (mon_tx !== 1'b0) begin
            timeout = 1'b1;
            bits = '1;
            return;
        end
        t_start = cyc;
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < div; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (c == 0) bits[i] = mon_tx;
                else if (mon_tx !== bits[i]) glitch = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = 8'h00;
        end
        in_data[0]  = 8'h99;
        in_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_line[0] !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", tx_line[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy[0]); end
        checks++; if (fcount[0] !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fcount[0]); end
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", in_ready[0]); end
        in_valid[0] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (fcount[0] !== 5'd0 || tx_line[0] !== 1'b1 || busy[0] !== 1'b0)
            begin errors++; $display("FAIL rst_write_dropped: count=%0d tx=%b busy=%b expected 0 1 0", fcount[0], tx_line[0], busy[0]); end
        checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready[0]); end
    endtask

    task automatic test_single();
        logic [12:0] bits;
        int acc, t0;
        bit gl, to;
        sel = 0;
        push_word(0, 8'h48, acc);
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL t1_busy_after_accept: got %b expected 1", busy[0]); end
        rx_frame(234, 10, bits, t0, gl, to);
        checks++; if (t0 - acc !== 1) begin errors++; $display("FAIL t1_latency: got %0d expected 1", t0 - acc); end
        checks++; if (bits !== 13'h290) begin errors++; $display("FAIL t1_frame: got %h expected 0290", bits); end
        checks++; if (gl || to) begin errors++; $display("FAIL t1_bit_timing: glitch=%b timeout=%b expected 0 0", gl, to); end
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL t1_busy_last_cycle: got %b expected 1", busy[0]); end
        @(negedge clk);
        checks++; if (busy[0] !== 1'b0 || tx_line[0] !== 1'b1 || cyc - t0 !== 2340)
            begin errors++; $display("FAIL t1_end: busy=%b tx=%b len=%0d expected 0 1 2340", busy[0], tx_line[0], cyc - t0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  hello [7];
        logic [12:0] frames [7];
        int          starts [7];
        int          acc0, drops, gaps;
        bit          gl, to, bad_timing;
        logic [4:0]  cnt_after;
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
        sel = 0; drops = 0; gaps = 0; bad_timing = 1'b0; acc0 = 0; cnt_after = '0;
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    in_data[0]  = hello[i];
                    in_valid[0] = 1'b1;
                    if (in_ready[0] !== 1'b1) drops++;
                    @(negedge clk);
                    if (i == 0) acc0 = cyc;
                end
                in_valid[0] = 1'b0;
                cnt_after = fcount[0];
            end
            begin
                for (int i = 0; i < 7; i++) begin
                    rx_frame(234, 10, frames[i], starts[i], gl, to);
                    if (gl || to) bad_timing = 1'b1;
                    if (to) break;
                end
            end
        join
        checks++; if (drops !== 0) begin errors++; $display("FAIL t2_ready_held: got %0d low cycles expected 0", drops); end
        checks++; if (cnt_after !== 5'd6) begin errors++; $display("FAIL t2_count_after_push: got %0d expected 6", cnt_after); end
        checks++; if (starts[0] - acc0 !== 1) begin errors++; $display("FAIL t2_latency: got %0d expected 1", starts[0] - acc0); end
        checks++; if (bad_timing) begin errors++; $display("FAIL t2_bit_timing: got 1 expected 0"); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (frames[i] !== {3'b000, 1'b1, hello[i], 1'b0})
                begin errors++; $display("FAIL t2_byte%0d: got %h expected %h", i, frames[i], {3'b000, 1'b1, hello[i], 1'b0}); end
            if (i > 0 && starts[i] - starts[i-1] != 2340) gaps++;
        end
        checks++; if (gaps !== 0) begin errors++; $display("FAIL t2_contiguous: got %0d gaps expected 0", gaps); end
        @(negedge clk);
        checks++; if (busy[0] !== 1'b0 || cyc - starts[0] !== 16380)
            begin errors++; $display("FAIL t2_total: busy=%b len=%0d expected 0 16380", busy[0], cyc - starts[0]); end
    endtask

    task automatic test_backpressure();
        logic [12:0] frames [20];
        int   t0, pushed, first_block, max_cnt, incons, guard;
        bit   gl, to, bad_timing;
        logic acc;
        sel = 1; pushed = 0; first_block = -1; max_cnt = 0; incons = 0; guard = 0; bad_timing = 1'b0;
        for (int i = 0; i < 20; i++) frames[i] = '1;
        fork
            begin
                while (pushed < 20 && guard < 5000) begin
                    in_data[1]  = 8'(pushed);
                    in_valid[1] = 1'b1;
                    acc = in_ready[1];
                    if (int'(fcount[1]) > max_cnt) max_cnt = int'(fcount[1]);
                    if (acc !== (fcount[1] < 5'd16)) incons++;
                    if (acc === 1'b0 && first_block < 0) first_block = pushed;
                    @(negedge clk);
                    guard++;
                    if (acc === 1'b1) pushed++;
                end
                in_valid[1] = 1'b0;
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    rx_frame(16, 10, frames[i], t0, gl, to);
                    if (gl || to) bad_timing = 1'b1;
                    if (to) break;
                end
            end
        join
        checks++; if (pushed !== 20) begin errors++; $display("FAIL t3_pushed: got %0d expected 20", pushed); end
        checks++; if (max_cnt !== 16) begin errors++; $display("FAIL t3_max_count: got %0d expected 16", max_cnt); end
        checks++; if (first_block !== 17) begin errors++; $display("FAIL t3_first_block: got %0d expected 17", first_block); end
        checks++; if (incons !== 0) begin errors++; $display("FAIL t3_ready_vs_count: got %0d bad cycles expected 0", incons); end
        checks++; if (bad_timing) begin errors++; $display("FAIL t3_bit_timing: got 1 expected 0"); end
        for (int i = 0; i < 20; i++) begin
            checks++; if (frames[i] !== {3'b000, 1'b1, 8'(i), 1'b0})
                begin errors++; $display("FAIL t3_byte%0d: got %h expected %h", i, frames[i], {3'b000, 1'b1, 8'(i), 1'b0}); end
        end
        @(negedge clk);
        checks++; if (busy[1] !== 1'b0 || fcount[1] !== 5'd0)
            begin errors++; $display("FAIL t3_drained: busy=%b count=%0d expected 0 0", busy[1], fcount[1]); end
    endtask

    task automatic test_parity();
        logic [12:0] f0, f1;
        int  t0, t1, acc;
        bit  g0, o0, g1, o1;
        sel = 2;
        fork
            begin
                push_word(2, 8'h55, acc);
                push_word(2, 8'h07, acc);
            end
            begin
                rx_frame(234, 11, f0, t0, g0, o0);
                rx_frame(234, 11, f1, t1, g1, o1);
            end
        join
        checks++; if (f0 !== 13'h04AA) begin errors++; $display("FAIL t4_even_55: got %h expected 04aa", f0); end
        checks++; if (f1 !== 13'h060E) begin errors++; $display("FAIL t4_even_07: got %h expected 060e", f1); end
        checks++; if (t1 - t0 !== 2574) begin errors++; $display("FAIL t4_even_len: got %0d expected 2574", t1 - t0); end
        checks++; if (g0 || o0 || g1 || o1) begin errors++; $display("FAIL t4_even_timing: got 1 expected 0"); end
        sel = 3;
        push_word(3, 8'h55, acc);
        rx_frame(234, 11, f0, t0, g0, o0);
        checks++; if (f0 !== 13'h06AA) begin errors++; $display("FAIL t4_odd_55: got %h expected 06aa", f0); end
        checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL t4_odd_busy_last: got %b expected 1", busy[3]); end
        @(negedge clk);
        checks++; if (busy[3] !== 1'b0 || cyc - t0 !== 2574 || g0 || o0)
            begin errors++; $display("FAIL t4_odd_len: busy=%b len=%0d glitch=%b expected 0 2574 0", busy[3], cyc - t0, g0); end
    endtask

    task automatic test_two_stop();
        logic [12:0] f0, f1;
        int  t0, t1, acc;
        bit  g0, o0, g1, o1;
        sel = 4;
        fork
            begin
                push_word(4, 8'h2A, acc);
                push_word(4, 8'h55, acc);
            end
            begin
                rx_frame(234, 10, f0, t0, g0, o0);
                rx_frame(234, 10, f1, t1, g1, o1);
            end
        join
        checks++; if (f0 !== 13'h0354) begin errors++; $display("FAIL t5_frame0: got %h expected 0354", f0); end
        checks++; if (f1 !== 13'h03AA) begin errors++; $display("FAIL t5_frame1: got %h expected 03aa", f1); end
        checks++; if (t1 - t0 !== 2340) begin errors++; $display("FAIL t5_len: got %0d expected 2340", t1 - t0); end
        checks++; if (g0 || o0 || g1 || o1) begin errors++; $display("FAIL t5_timing: got 1 expected 0"); end
        @(negedge clk);
        checks++; if (busy[4] !== 1'b0 || cyc - t1 !== 2340)
            begin errors++; $display("FAIL t5_end: busy=%b len=%0d expected 0 2340", busy[4], cyc - t1); end
    endtask

    task automatic test_reset_mid_frame();
        logic [12:0] f0;
        int  t0, acc, bad_idle;
        bit  g0, o0;
        sel = 0; bad_idle = 0;
        fork
            begin
                push_word(0, 8'h11, acc);
                push_word(0, 8'h22, acc);
                push_word(0, 8'h33, acc);
            end
            rx_frame(234, 10, f0, t0, g0, o0);
        join
        checks++; if (f0 !== 13'h0222) begin errors++; $display("FAIL t6_frame0: got %h expected 0222", f0); end
        // Second frame starts at t0+2340; data bit 3 spans offsets 936..1169.
        repeat (1001) @(negedge clk);
        checks++; if (tx_line[0] !== 1'b0 || fcount[0] !== 5'd1)
            begin errors++; $display("FAIL t6_pre_reset: tx=%b count=%0d expected 0 1", tx_line[0], fcount[0]); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL t6_ready_in_reset: got %b expected 0", in_ready[0]); end
        @(negedge clk);
        checks++; if (tx_line[0] !== 1'b1 || fcount[0] !== 5'd0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0)
            begin errors++; $display("FAIL t6_reset_state: tx=%b count=%0d busy=%b ready=%b expected 1 0 0 0",
                                     tx_line[0], fcount[0], busy[0], in_ready[0]); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_line[0] !== 1'b1 || busy[0] !== 1'b0) bad_idle++;
        end
        checks++; if (bad_idle !== 0) begin errors++; $display("FAIL t6_no_resume: got %0d active cycles expected 0", bad_idle); end
        push_word(0, 8'hA5, acc);
        rx_frame(234, 10, f0, t0, g0, o0);
        checks++; if (f0 !== 13'h034A) begin errors++; $display("FAIL t6_a5_frame: got %h expected 034a", f0); end
        checks++; if (t0 - acc !== 1 || g0 || o0)
            begin errors++; $display("FAIL t6_a5_timing: latency=%0d glitch=%b expected 1 0", t0 - acc, g0); end
        @(negedge clk);
        checks++; if (busy[0] !== 1'b0 || cyc - t0 !== 2340)
            begin errors++; $display("FAIL t6_a5_len: busy=%b len=%0d expected 0 2340", busy[0], cyc - t0); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        sel    = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_parity();
        test_two_stop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
